// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: default widths,
// the per-edge action encoding and the fill-width helper.
package seq_det_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    // What the detector does with its history/fill on a given clock edge.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_SHIFT,
        ACT_MATCH_KEEP,
        ACT_MATCH_RESTART
    } edge_action_e;

    // fill counts 0..PAT_W inclusive, so it needs clog2(PAT_W+1) bits.
    function automatic int fill_width(input int patW);
        return $clog2(patW + 1);
    endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter. A clear wins over the old value, but a hit on
// the same edge as a clear still counts, so the result is 1 rather than 0.
module seq_hit_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear (optionally with a coincident hit), else saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial pattern detector with a loadable PAT_W-bit target, overlapping or
// non-overlapping matching, a registered match pulse and a saturating count.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_in,
    input  logic                          valid_in,
    input  logic [PAT_W-1:0]              pattern,
    input  logic                          pat_load,
    input  logic                          overlap_en,
    input  logic                          clear_cnt,
    output logic                          detected,
    output logic [CNT_W-1:0]              det_count,
    output logic [fill_width(PAT_W)-1:0]  fill
);

    localparam int FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  pat_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              det_q;
    logic              det_d;

    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_inc;
    logic              candidate;
    logic              hit;
    edge_action_e      action;

    // The window that would be in history after this edge, and whether it completes the target.
    always_comb begin
        shifted   = {hist_q[PAT_W-2:0], data_in};
        fill_inc  = (fill_q == FILL_FULL) ? fill_q : (fill_q + FILL_W'(1));
        candidate = (fill_q >= FILL_ARM) && (shifted == pat_q);
    end

    // Decide this edge's action; a pattern load overrides sampling and suppresses any match.
    always_comb begin
        action = ACT_HOLD;
        if (pat_load) begin
            action = ACT_LOAD;
        end else if (valid_in) begin
            if (candidate) begin
                action = overlap_en ? ACT_MATCH_KEEP : ACT_MATCH_RESTART;
            end else begin
                action = ACT_SHIFT;
            end
        end
    end

    // Next-state for history, fill, pattern and the match pulse.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        hit    = 1'b0;
        case (action)
            ACT_LOAD: begin
                pat_d  = pattern;
                fill_d = '0;
            end
            ACT_SHIFT: begin
                hist_d = shifted;
                fill_d = fill_inc;
            end
            ACT_MATCH_KEEP: begin
                hist_d = shifted;
                fill_d = fill_inc;
                hit    = 1'b1;
            end
            ACT_MATCH_RESTART: begin
                hist_d = shifted;
                fill_d = '0;
                hit    = 1'b1;
            end
            default: begin
                hist_d = hist_q;
            end
        endcase
        det_d = hit;
    end

    // Detector state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            pat_q  <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    seq_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clear_cnt),
        .count (det_count)
    );

    assign detected = det_q;
    assign fill     = fill_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: a vector table for the basic scenarios,
// hand-written reset/load/saturation sequences, and a random run against a
// queue-based reference model.
module tb_param_seq_detector;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic       valid_in;
    logic       pat_load;
    logic       overlap_en;
    logic       clear_cnt;
    logic [3:0] pattern;
    logic [1:0] pattern2;

    logic       detected;
    logic [7:0] det_count;
    logic [2:0] fill;
    logic       detected2;
    logic [1:0] det_count2;
    logic [1:0] fill2;

    int compared;
    int mismatched;

    typedef struct {
        logic       load;
        logic       dataIn;
        logic       validIn;
        logic       overlapEn;
        logic       clearCnt;
        logic       expDet;
        logic [7:0] expCnt;
        logic [2:0] expFill;
    } vecT;

    vecT vecs[$];

    bit         mq[$];
    logic [3:0] patM;
    logic [3:0] lastBits;
    int         cntM;
    logic       hitM;
    logic       rLd, rD, rV, rOv, rClr;

    param_seq_detector #(.PAT_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .pattern    (pattern),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .clear_cnt  (clear_cnt),
        .detected   (detected),
        .det_count  (det_count),
        .fill       (fill)
    );

    param_seq_detector #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .pattern    (pattern2),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .clear_cnt  (clear_cnt),
        .detected   (detected2),
        .det_count  (det_count2),
        .fill       (fill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input int ld, input int d, input int v, input int ov,
                                   input int clr, input int det, input int cnt, input int f);
        vecT r;
        r.load      = ld[0];
        r.dataIn    = d[0];
        r.validIn   = v[0];
        r.overlapEn = ov[0];
        r.clearCnt  = clr[0];
        r.expDet    = det[0];
        r.expCnt    = cnt[7:0];
        r.expFill   = f[2:0];
        vecs.push_back(r);
    endfunction

    task automatic applyStimulus(input logic ld, input logic d, input logic v,
                                 input logic ov, input logic clr);
        pat_load   = ld;
        data_in    = d;
        valid_in   = v;
        overlap_en = ov;
        clear_cnt  = clr;
        @(posedge clk);
        #1;
        pat_load   = 1'b0;
        clear_cnt  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic resetAll();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        data_in    = 1'b0;
        valid_in   = 1'b0;
        pat_load   = 1'b0;
        overlap_en = 1'b1;
        clear_cnt  = 1'b0;
        pattern    = 4'b1011;
        pattern2   = 2'b11;

        #12;
        checkOutput("reset_detected", 32'(detected), 32'd0);
        checkOutput("reset_count", 32'(det_count), 32'd0);
        checkOutput("reset_fill", 32'(fill), 32'd0);
        reset = 1'b1;

        // Overlapping run 1011 in 1,0,1,1,0,1,1
        addVec(1,0,0,1,0, 0,0,0);
        addVec(0,1,1,1,0, 0,0,1);
        addVec(0,0,1,1,0, 0,0,2);
        addVec(0,1,1,1,0, 0,0,3);
        addVec(0,1,1,1,0, 1,1,4);
        addVec(0,0,1,1,0, 0,1,4);
        addVec(0,1,1,1,0, 0,1,4);
        addVec(0,1,1,1,0, 1,2,4);
        addVec(0,1,0,1,0, 0,2,4);
        // Non-overlapping run; the load edge has valid high and must not sample
        addVec(1,1,1,0,0, 0,2,0);
        addVec(0,0,0,0,1, 0,0,0);
        addVec(0,1,1,0,0, 0,0,1);
        addVec(0,0,1,0,0, 0,0,2);
        addVec(0,1,1,0,0, 0,0,3);
        addVec(0,1,1,0,0, 1,1,0);
        addVec(0,0,1,0,0, 0,1,1);
        addVec(0,1,1,0,0, 0,1,2);
        addVec(0,1,1,0,0, 0,1,3);
        addVec(0,0,0,0,0, 0,1,3);
        // Valid gap in the middle of a pattern; data toggling in the gap is ignored
        addVec(1,0,0,1,0, 0,1,0);
        addVec(0,0,0,1,1, 0,0,0);
        addVec(0,1,1,1,0, 0,0,1);
        addVec(0,0,1,1,0, 0,0,2);
        addVec(0,1,1,1,0, 0,0,3);
        addVec(0,1,0,1,0, 0,0,3);
        addVec(0,0,0,1,0, 0,0,3);
        addVec(0,1,0,1,0, 0,0,3);
        addVec(0,1,1,1,0, 1,1,4);
        addVec(0,0,0,1,0, 0,1,4);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].load, vecs[i].dataIn, vecs[i].validIn,
                          vecs[i].overlapEn, vecs[i].clearCnt);
            checkOutput($sformatf("vec%0d_detected", i), 32'(detected), 32'(vecs[i].expDet));
            checkOutput($sformatf("vec%0d_count", i), 32'(det_count), 32'(vecs[i].expCnt));
            checkOutput($sformatf("vec%0d_fill", i), 32'(fill), 32'(vecs[i].expFill));
        end

        // Reset mid-stream discards the partial 1,0,1
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset_fill", 32'(fill), 32'd0);
        checkOutput("midreset_count", 32'(det_count), 32'd0);
        checkOutput("midreset_detected", 32'(detected), 32'd0);
        #2;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("postreset_bit1_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("postreset_bit2_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("postreset_bit3_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("postreset_bit4_det", 32'(detected), 32'd1);
        checkOutput("postreset_count", 32'(det_count), 32'd1);

        // Reset beats a simultaneous pat_load: pattern register must read back as 0000
        reset    = 1'b0;
        pat_load = 1'b1;
        pattern  = 4'b1111;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        pattern  = 4'b1011;
        reset    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("zeropat_det%0d", k), 32'(detected), (k == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("zeropat_fill", 32'(fill), 32'd4);

        // Loading a new pattern after 1,0,1 restarts the fill
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        pattern = 4'b0110;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reload_fill", 32'(fill), 32'd0);
        checkOutput("reload_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("reload_b1_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reload_b2_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reload_b3_det", 32'(detected), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("reload_b4_det", 32'(detected), 32'd1);

        // Narrow counter saturation and clear-with-hit on the PAT_W=2 instance
        resetAll();
        pattern2 = 2'b11;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("sat_det%0d", k), 32'(detected2), (k == 0) ? 32'd0 : 32'd1);
            checkOutput($sformatf("sat_cnt%0d", k), 32'(det_count2), (k > 3) ? 32'd3 : 32'(k));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("sat_cleared", 32'(det_count2), 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("sat_full", 32'(det_count2), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_hit_cnt", 32'(det_count2), 32'd1);
        checkOutput("clr_hit_det", 32'(detected2), 32'd1);

        // Random run against the fresh-bit queue model
        resetAll();
        mq.delete();
        patM = 4'b0000;
        cntM = 0;
        rOv  = 1'b1;
        for (int n = 0; n < 800; n++) begin
            rLd  = ($urandom_range(0, 15) == 0);
            rD   = 1'($urandom_range(0, 1));
            rV   = ($urandom_range(0, 3) != 0);
            rClr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) rOv = ~rOv;
            pattern = 4'($urandom);
            hitM = 1'b0;
            if (rLd) begin
                mq.delete();
                patM = pattern;
            end else if (rV) begin
                mq.push_back(rD);
                if (mq.size() >= 4) begin
                    for (int k = 0; k < 4; k++) lastBits[3-k] = mq[mq.size() - 4 + k];
                    hitM = (lastBits == patM);
                end
                if (hitM && !rOv) mq.delete();
                while (mq.size() > 4) void'(mq.pop_front());
            end
            if (rClr) cntM = hitM ? 1 : 0;
            else if (hitM && cntM < 255) cntM++;
            applyStimulus(rLd, rD, rV, rOv, rClr);
            checkOutput($sformatf("rnd%0d_det", n), 32'(detected), 32'(hitM));
            checkOutput($sformatf("rnd%0d_cnt", n), 32'(det_count), 32'(cntM));
            checkOutput($sformatf("rnd%0d_fill", n), 32'(fill), 32'(mq.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, serial pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the detection counter (legal range 1..16).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port data_in  input  1  serial data bit, sampled only when valid_in=1.
REQ-006 The block SHALL have port valid_in  input  1  sample enable; when 0, no history or count change occurs.
REQ-007 The block SHALL have port pattern  input  PAT_W  target pattern, MSB first in time, captured only on pat_load.
REQ-008 The block SHALL have port pat_load  input  1  loads pattern into internal pattern register.
REQ-009 The block SHALL have port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 The block SHALL have port clear_cnt  input  1  synchronous clear of det_count.
REQ-011 The block SHALL have port detected  output  1  one-cycle pulse per match, registered.
REQ-012 The block SHALL have port det_count  output  CNT_W  saturating count of matches.
REQ-013 The block SHALL have port fill  output  clog2(PAT_W+1)  number of valid history bits, saturating at PAT_W.

Function
REQ-014 On each valid_in=1 edge, the history register SHALL shift left by one with data_in entering at bit 0, and fill SHALL increment, saturating at PAT_W.
REQ-015 A match SHALL be declared on a valid_in=1 edge when fill >= PAT_W-1 before the edge and {history[PAT_W-2:0], data_in} equals the pattern register.
REQ-016 detected SHALL be 1 in the cycle following the matching edge and 0 otherwise, giving a latency of 1 clock from the last pattern bit.
REQ-017 In overlap mode, history and fill SHALL be unaffected by a match, so the suffix bits remain eligible for the next match.
REQ-018 In non-overlap mode, a match SHALL clear fill to 0 on the same edge, and the next match SHALL require PAT_W fresh bits.
REQ-019 overlap_en MAY change at any time and SHALL take effect at the next valid_in=1 edge.
REQ-020 pat_load=1 SHALL capture pattern, clear fill to 0 and suppress a match on that edge, regardless of valid_in.
REQ-021 det_count SHALL increment by 1 per match and hold at 2^CNT_W-1 without wrap.
REQ-022 If clear_cnt=1 and a match occur on the same edge, det_count SHALL become 1; clear_cnt without a match SHALL make det_count 0.
REQ-023 When valid_in=0, detected SHALL be 0 in the following cycle, and history, fill and det_count SHALL hold.

Reset
REQ-024 reset=0 SHALL asynchronously force history=0, fill=0, pattern register=0, detected=0 and det_count=0.
REQ-025 Reset deasserted mid-stream SHALL discard all partial history, and no match SHALL be declared until PAT_W new valid bits have been sampled.
REQ-026 Reset SHALL take priority over pat_load, clear_cnt and valid_in.

Structure
REQ-027 Package seq_det_pkg SHALL hold default PAT_W, default CNT_W and a function computing the width of fill.
REQ-028 Saturating counter sub-module seq_hit_counter (params CNT_W; inputs inc, clr) SHALL implement REQ-021 and REQ-022.
REQ-029 The design SHALL contain no latches, and all outputs SHALL be driven directly from flops.

Verification
REQ-030 PAT_W=4, pattern=1011, overlap_en=1, stream 1,0,1,1,0,1,1 -> detected pulses after bits 4 and 7; det_count=2.
REQ-031 Same stream with overlap_en=0 -> single pulse after bit 4; det_count=1.
REQ-032 Pattern 1011, stream 1,0,1 then valid_in=0 for 3 cycles then 1 -> pulse one cycle after the final valid bit; no pulse during the gap.
REQ-033 Reset pulsed low after bits 1,0,1, then stream 1,0,1,1 -> no pulse on the first post-reset 1; one pulse after the fourth post-reset bit.
REQ-034 CNT_W=2, pattern 11, stream of 5 ones with overlap_en=1 -> 4 pulses; det_count saturates at 3; clear_cnt coincident with the 5th-bit match -> det_count=1.
REQ-035 pat_load of 0110 after 1,0,1 was sampled -> fill=0, and no match occurs until 0,1,1,0 is received in full.
